decode_2_4: RTL and testbench

- Registered 2-to-4 line decoder with an active-low enable.
- Converts a 2-bit binary select into a 4-bit active-high one-hot code, captured on the rising clock edge.
- Used as a small address/select decoder feeding chip-select or mux-select logic in synchronous datapaths.
- All outputs are registered, so downstream logic sees glitch-free selects.

---
 rtl/decode_2_4.sv | 53 +++++
 tb/tb_decode_2_4.sv | 123 ++++++++++++
 2 files changed

// File: rtl/decode_2_4.sv
// decode_2_4 -- registered 2-to-4 line decoder with active-low enable.
//
// Turns a binary select into an active-high one-hot code, captured on the
// rising clock edge, so downstream chip-select / mux-select logic sees
// glitch-free selects. Nothing combinational reaches the outputs.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous reset, active-high
//   indata    in   IN_W   binary select code
//   enable_n  in   1      active-low decode enable (1 = disabled)
//   outdata   out  OUT_W  registered one-hot decode, all-zero when disabled
//   out_valid out  1      registered ~enable_n; 1 when outdata holds a code
module decode_2_4 #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  indata,
  input  logic             enable_n,
  output logic [OUT_W-1:0] outdata,
  output logic             out_valid
);

  logic [OUT_W-1:0] outdata_d, outdata_q;
  logic             valid_d,   valid_q;

  // A shift is used instead of a case table so an unknown select
  // propagates as X in simulation rather than landing in a default arm.
  always_comb begin
    outdata_d = '0;
    valid_d   = 1'b0;
    if (!enable_n) begin
      outdata_d = OUT_W'(1) << indata;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outdata_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      outdata_q <= outdata_d;
      valid_q   <= valid_d;
    end
  end

  assign outdata   = outdata_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_decode_2_4.sv
// Self-checking bench for decode_2_4: vector table plus hand-written
// sequences for asynchronous reset and mid-cycle input glitches.
module tb_decode_2_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] indata = 2'b11;
  logic       enable_n = 1'b0;
  logic [3:0] outdata;
  logic       out_valid;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;

  decode_2_4 dut (
    .clk      (clk),
    .rst      (rst),
    .indata   (indata),
    .enable_n (enable_n),
    .outdata  (outdata),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en_n;
    logic [1:0] din;
    logic [3:0] exp_out;
    logic       exp_vld;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got vld,out=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, check just after the following rising edge.
  task automatic cycle(input string name, input logic r, input logic en_n,
                       input logic [1:0] d, input logic [3:0] eo, input logic ev);
    @(negedge clk);
    rst = r; enable_n = en_n; indata = d;
    @(posedge clk);
    #1;
    chk(name, {out_valid, outdata}, {ev, eo});
  endtask

  // Outputs are all-zero or one-hot, and all-zero exactly when not valid.
  always @(negedge clk) begin
    if (mon_on) begin
      n_chk++;
      if (!($onehot0(outdata) && ((outdata == 4'b0000) == !out_valid))) begin
        n_fail++;
        $display("FAIL invariant: out=%b vld=%b at %0t", outdata, out_valid, $time);
      end
    end
  end

  initial begin
    // rst, en_n, din, expected out, expected valid
    vecs[0]  = '{1'b1, 1'b0, 2'b11, 4'b0000, 1'b0};  // reset held
    vecs[1]  = '{1'b1, 1'b0, 2'b11, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'b11, 4'b1000, 1'b1};  // release
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 4'b0000, 1'b0};  // disabled
    vecs[4]  = '{1'b0, 1'b1, 2'b00, 4'b0000, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'b10, 4'b0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'b10, 4'b0000, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'b00, 4'b0001, 1'b1};  // sweep
    vecs[8]  = '{1'b0, 1'b0, 2'b01, 4'b0010, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 2'b10, 4'b0100, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 2'b11, 4'b1000, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 2'b01, 4'b0010, 1'b1};  // enable toggle
    vecs[12] = '{1'b0, 1'b1, 2'b01, 4'b0000, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 2'b01, 4'b0010, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 2'b11, 4'b1000, 1'b1};  // back-to-back codes
    vecs[15] = '{1'b0, 1'b0, 2'b00, 4'b0001, 1'b1};

    #1;
    chk("reset_initial", {out_valid, outdata}, 5'b0_0000);
    mon_on = 1'b1;

    for (int i = 0; i < 16; i++)
      cycle($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en_n, vecs[i].din,
            vecs[i].exp_out, vecs[i].exp_vld);

    // Async reset between edges while holding 0100.
    cycle("pre_async", 1'b0, 1'b0, 2'b10, 4'b0100, 1'b1);
    #2 rst = 1'b1;
    #1 chk("async_clear", {out_valid, outdata}, 5'b0_0000);
    #1 rst = 1'b0;
    #1 chk("async_hold", {out_valid, outdata}, 5'b0_0000);
    @(posedge clk); #1;
    chk("async_resume", {out_valid, outdata}, 5'b1_0100);

    // Glitch on indata between edges must not reach the outputs.
    cycle("pre_glitch", 1'b0, 1'b0, 2'b01, 4'b0010, 1'b1);
    #1 indata = 2'b10;
    #1 chk("glitch_mid", {out_valid, outdata}, 5'b1_0010);
    #1 indata = 2'b01;
    #1 chk("glitch_back", {out_valid, outdata}, 5'b1_0010);
    @(posedge clk); #1;
    chk("glitch_edge", {out_valid, outdata}, 5'b1_0010);

    // Enable toggled mid-cycle and restored before the edge: no effect.
    #1 enable_n = 1'b1;
    #2 enable_n = 1'b0;
    @(posedge clk); #1;
    chk("en_glitch", {out_valid, outdata}, 5'b1_0010);

    @(negedge clk);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
